lcd_pixel_fifo: RTL

Pixel buffer between a pixel source (pattern generator, SDRAM/PSRAM reader, or host bridge) and the LCD sync stage. It accepts RGB565 pixels over a valid/ready stream tagged with start-of-frame. It pops one pixel per active-video cycle from the LCD timing generator's DE/HSYNC/VSYNC, and presents registered, aligned DE/HSYNC/VSYNC/R/G/B to the panel pins. It enforces frame alignment and recovers automatically from underflow or sync loss.

---
 rtl/lcd_pixel_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lcd_pixel_fifo.sv
// RGB565 pixel FIFO from a SOF-tagged valid/ready stream to registered LCD panel pins, with frame alignment and error recovery.
// Build option: LCD_PIXEL_FIFO_DEBUG_COLOR_EN selects a magenta fill colour instead of black.

module lcd_pixel_fifo #(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          PixelClk,
    input  logic          RST,
    input  logic [15:0]   S_DATA,
    input  logic          S_SOF,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic          TG_DE,
    input  logic          TG_HSYNC,
    input  logic          TG_VSYNC,
    input  logic          ERR_CLR,
    output logic          LCD_DE,
    output logic          LCD_HSYNC,
    output logic          LCD_VSYNC,
    output logic [4:0]    LCD_R,
    output logic [5:0]    LCD_G,
    output logic [4:0]    LCD_B,
    output logic [AW:0]   LEVEL,
    output logic          UNDERFLOW,
    output logic          SYNC_ERR
);

`ifdef LCD_PIXEL_FIFO_DEBUG_COLOR_EN
    localparam logic [15:0] FILL_RGB = 16'hF81F;
`else
    localparam logic [15:0] FILL_RGB = 16'h0000;
`endif

    localparam logic [AW:0] HALF_LEVEL = (AW+1)'(DEPTH / 2);

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [AW:0] level_q, level_d;
    logic        vs_q, vs_d;
    logic        first_px_q, first_px_d;
    logic        underflow_q, underflow_d;
    logic        sync_err_q, sync_err_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vsync_q, vsync_d;
    logic [15:0] rgb_q, rgb_d;

    logic [16:0] mem_q [DEPTH];

    logic        full_c, empty_c, ready_c, vs_fall_c;
    logic        pop_c, underflow_c, sync_err_c, flush_c, push_c, show_c;
    logic [16:0] head_c;

    // Occupancy flags from the extra pointer MSB; head entry is {SOF, pixel}
    always_comb begin
        full_c    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty_c   = (wr_q == rd_q);
        head_c    = mem_q[rd_q[AW-1:0]];
        vs_fall_c = vs_q && !TG_VSYNC;
        ready_c   = !RST && ((state_q == ST_ALIGN) || !full_c);
    end

    assign S_READY = ready_c;

    // Pop/error decode and next-state logic
    always_comb begin
        pop_c       = (state_q == ST_RUN) && TG_DE && !empty_c;
        underflow_c = (state_q == ST_RUN) && TG_DE && empty_c;
        sync_err_c  = pop_c && (head_c[16] != first_px_q);
        flush_c     = underflow_c || sync_err_c;
        show_c      = pop_c && !sync_err_c;
        push_c      = S_VALID && ready_c && !flush_c &&
                      ((state_q != ST_ALIGN) || S_SOF);

        state_d     = state_q;
        first_px_d  = first_px_q;
        wr_d        = wr_q + (AW+1)'(push_c);
        rd_d        = rd_q + (AW+1)'(pop_c);
        level_d     = level_q + (AW+1)'(push_c) - (AW+1)'(pop_c);

        case (state_q)
            ST_ALIGN: begin
                if (push_c) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (vs_fall_c && (level_q >= HALF_LEVEL)) begin
                    state_d    = ST_RUN;
                    first_px_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (pop_c)     first_px_d = 1'b0;
                if (vs_fall_c) first_px_d = 1'b1;
                if (flush_c)   state_d    = ST_ALIGN;
            end
            default: state_d = ST_ALIGN;
        endcase

        if (flush_c) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end

        underflow_d = (underflow_q && !ERR_CLR) || underflow_c;
        sync_err_d  = (sync_err_q && !ERR_CLR) || sync_err_c;

        vs_d    = TG_VSYNC;
        de_d    = TG_DE;
        hs_d    = TG_HSYNC;
        vsync_d = TG_VSYNC;
        if (!TG_DE)      rgb_d = 16'h0000;
        else if (show_c) rgb_d = head_c[15:0];
        else             rgb_d = FILL_RGB;
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            state_q     <= ST_ALIGN;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            vs_q        <= 1'b1;
            first_px_q  <= 1'b0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
            vs_q        <= vs_d;
            first_px_q  <= first_px_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
        end
    end

    // Storage array carries no reset; contents are meaningless once pointers are cleared
    always_ff @(posedge PixelClk) begin
        if (push_c) mem_q[wr_q[AW-1:0]] <= {S_SOF, S_DATA};
    end

    assign LCD_DE    = de_q;
    assign LCD_HSYNC = hs_q;
    assign LCD_VSYNC = vsync_q;
    assign LCD_R     = rgb_q[15:11];
    assign LCD_G     = rgb_q[10:5];
    assign LCD_B     = rgb_q[4:0];
    assign LEVEL     = level_q;
    assign UNDERFLOW = underflow_q;
    assign SYNC_ERR  = sync_err_q;

endmodule
